// File: rtl/xornand_seq_if.sv
// Request/response handshake bundle for xornand_seq: operands in, result and carry out.
interface xornand_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/xornand_seq.sv
// Bit-serial XOR/NAND/AND sequencer (ADD when XORNAND_SEQ_ADD_EN is defined), LSB first, one bit per clk.
// out_valid rises WIDTH+1 clks after accept; result held in DONE until out_ready; in_ready only in IDLE.
module xornand_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  xornand_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;

  // Shared slice on the current operand bits.
  logic             w_q1;
  logic             w_n1;
  logic             w_bit;
  logic [WIDTH-1:0] w_res_full;

  assign w_q1 = r_a_sr[0] ^ r_b_sr[0];
  assign w_n1 = ~(r_a_sr[0] & r_b_sr[0]);

`ifdef XORNAND_SEQ_ADD_EN
  logic r_cy;
  logic r_carry_out;
  logic w_q2;
  logic w_n2;
  logic w_cout;

  // Second slice folds carry-in; carry-out is NAND of both slices' NAND outputs.
  assign w_q2   = w_q1 ^ r_cy;
  assign w_n2   = ~(w_q1 & r_cy);
  assign w_cout = ~(w_n1 & w_n2);
`endif

  always_comb begin
    w_bit = w_q1;
    case (r_op)
      OP_XOR:  w_bit = w_q1;
      OP_NAND: w_bit = w_n1;
      OP_AND:  w_bit = ~w_n1;
`ifdef XORNAND_SEQ_ADD_EN
      OP_ADD:  w_bit = w_q2;
`else
      OP_ADD:  w_bit = w_q1;
`endif
      default: w_bit = w_q1;
    endcase
  end

  // Earliest result bit ends up at bit 0 once WIDTH bits have entered from the top.
  assign w_res_full = {w_bit, r_res_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res_sr    <= '0;
      r_op        <= OP_XOR;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
`ifdef XORNAND_SEQ_ADD_EN
      r_cy        <= 1'b0;
      r_carry_out <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_op    <= bus.op;
            r_cnt   <= '0;
`ifdef XORNAND_SEQ_ADD_EN
            r_cy    <= 1'b0;
`endif
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_full[WIDTH-1:1];
          r_cnt    <= r_cnt + 1'b1;
`ifdef XORNAND_SEQ_ADD_EN
          r_cy     <= w_cout;
`endif
          if (r_cnt == LAST_BIT) begin
            r_result    <= w_res_full;
`ifdef XORNAND_SEQ_ADD_EN
            r_carry_out <= (r_op == OP_ADD) ? w_cout : 1'b0;
`endif
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
`ifdef XORNAND_SEQ_ADD_EN
  assign bus.carry_out = r_carry_out;
`else
  assign bus.carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_xornand_seq.sv
// Directed and random checks of xornand_seq against an arithmetic reference model.
module tb_xornand_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] prev_res = '0;
  logic         prev_cy  = 1'b0;

  xornand_seq_if #(.WIDTH(W)) bus ();

  xornand_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic; returns {carry, result}.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return {1'b0, a ^ b};
      2'b01:   return {1'b0, ~(a & b)};
      2'b11:   return {1'b0, a & b};
`ifdef XORNAND_SEQ_ADD_EN
      default: return {1'b0, a} + {1'b0, b};
`else
      default: return {1'b0, a ^ b};
`endif
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_cy, input int stall);
    int   lat;
    logic hold_ok;
    logic bp_ok;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.op       = 2'($urandom);
    lat     = 1;
    hold_ok = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && lat < 4 * W) begin
      if (bus.result !== prev_res || bus.carry_out !== prev_cy || bus.in_ready !== 1'b0)
        hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_hold_during_run"}, 32'(hold_ok), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_cy));
    bp_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.result !== exp_res ||
          bus.carry_out !== exp_cy || bus.in_ready !== 1'b0)
        bp_ok = 1'b0;
    end
    if (stall > 0) check({tag, "_stable_under_backpressure"}, 32'(bp_ok), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_dropped"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    prev_res = exp_res;
    prev_cy  = exp_cy;
  endtask

  initial begin
    logic [W:0]   m;
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carry_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    run_op("xor", 2'b00, 8'hA5, 8'h0F, 8'hAA, 1'b0, 0);
    run_op("nand", 2'b01, 8'hF0, 8'hCC, 8'h3F, 1'b0, 0);
    run_op("and", 2'b11, 8'hF0, 8'hCC, 8'hC0, 1'b0, 0);
`ifdef XORNAND_SEQ_ADD_EN
    run_op("add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
    run_op("add_3c_42", 2'b10, 8'h3C, 8'h42, 8'h7E, 1'b0, 0);
    run_op("xor_after_add", 2'b00, 8'h12, 8'h34, 8'h26, 1'b0, 0);
`else
    run_op("add_as_xor", 2'b10, 8'h12, 8'h34, 8'h26, 1'b0, 0);
    run_op("add_as_xor2", 2'b10, 8'hFF, 8'h01, 8'hFE, 1'b0, 0);
`endif

    // Backpressure: 5 cycles in DONE with out_ready low
    run_op("backpressure", 2'b01, 8'h5A, 8'h3C, 8'hE7, 1'b0, 5);

    // Reset while bit 3 of an ADD is in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b10;
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_carry", 32'(bus.carry_out), 32'd0);
    prev_res = '0;
    prev_cy  = 1'b0;
    run_op("after_abort", 2'b00, 8'h01, 8'h03, 8'h02, 1'b0, 0);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom);
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, m[W-1:0], m[W], $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
